// File: rtl/axi_write_pkg.sv
// Shared definitions for the 256-bit AXI4 writer path: default widths and the
// command-issue state encoding.
package axi_write_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 256;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty come from the count
// register, pointers wrap naturally at DEPTH (a power of two).
module sync_fifo #(
  parameter int WIDTH = 320,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full queue refuses a push even when it pops in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Head is read combinationally so the issuer can latch it in the same
  // cycle it decides to pop.
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_write_cmd_queue.sv
// Buffers producer write requests and issues them one at a time to the AXI4
// writer over its ap_ctrl handshake, in acceptance order.
module axi_write_cmd_queue
  import axi_write_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              writer_start,
  input  logic              writer_ready,
  input  logic              writer_idle,
  input  logic              writer_done,
  output logic [ADDR_W-1:0] writer_addr,
  output logic [DATA_W-1:0] writer_data,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic [31:0]       done_count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  wr_state_e          state_q;
  logic               start_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [31:0]        done_count_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;

  // Pop only from IDLE: a push into an empty queue is issued the next cycle.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty && writer_idle;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({in_addr, in_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      done_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            addr_q  <= fifo_head[ENTRY_W-1:DATA_W];
            data_q  <= fifo_head[DATA_W-1:0];
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          // done coinciding with ready completes the transaction outright.
          if (writer_ready) begin
            start_q <= 1'b0;
            if (writer_done) begin
              done_count_q <= done_count_q + 32'd1;
              state_q      <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (writer_done) begin
            done_count_q <= done_count_q + 32'd1;
            state_q      <= IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = !fifo_full;
  assign writer_start = start_q;
  assign writer_addr  = addr_q;
  assign writer_data  = data_q;
  assign done_count   = done_count_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_axi_write_cmd_queue.sv
// Self-checking bench for axi_write_cmd_queue: a behavioural writer agent,
// an in-order request scoreboard and directed plus randomized scenarios.
module tb_axi_write_cmd_queue;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 8;

  typedef logic [ADDR_W+DATA_W-1:0] req_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              writer_start;
  logic              writer_ready;
  logic              writer_idle;
  logic              writer_done;
  logic [ADDR_W-1:0] writer_addr;
  logic [DATA_W-1:0] writer_data;
  logic [3:0]        level;
  logic              busy;
  logic [31:0]       done_count;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_done = 0;

  // writer agent controls
  int rdy_dly = 0;
  int done_dly = 3;
  bit hold_busy = 1'b0;
  int spur_req = 0;

  // scoreboard state, written only by the monitor
  req_t acc_q[$];
  req_t issued_q[$];
  int   acc = 0;
  int   issues = 0;
  int   model_done = 0;
  bit   outst = 1'b0;
  bit   prev_start = 1'b0;
  int   lvl_err = 0;
  int   rdy_err = 0;
  int   cnt_err = 0;
  int   ord_err = 0;

  always #5 clock = ~clock;

  axi_write_cmd_queue dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .writer_start (writer_start),
    .writer_ready (writer_ready),
    .writer_idle  (writer_idle),
    .writer_done  (writer_done),
    .writer_addr  (writer_addr),
    .writer_data  (writer_data),
    .level        (level),
    .busy         (busy),
    .done_count   (done_count)
  );

  // Writer: ready rdy_dly cycles after start is seen, done done_dly cycles after ready.
  initial begin : writer_agent
    int ph;
    int cnt;
    int spur_seen;
    ph = 0;
    cnt = 0;
    spur_seen = 0;
    writer_ready = 1'b0;
    writer_done  = 1'b0;
    writer_idle  = 1'b1;
    forever begin
      @(negedge clock);
      writer_ready = 1'b0;
      writer_done  = 1'b0;
      if (reset) begin
        ph = 0;
      end else begin
        if (ph == 0 && writer_start) begin
          cnt = rdy_dly;
          ph = 1;
        end
        if (ph == 1) begin
          if (cnt == 0) begin
            writer_ready = 1'b1;
            if (done_dly == 0) begin
              writer_done = 1'b1;
              ph = 0;
            end else begin
              cnt = done_dly;
              ph = 2;
            end
          end else begin
            cnt--;
          end
        end else if (ph == 2) begin
          cnt--;
          if (cnt == 0) begin
            writer_done = 1'b1;
            ph = 0;
          end
        end else if (spur_seen != spur_req) begin
          writer_done = 1'b1;
          spur_seen++;
        end
      end
      writer_idle = (ph == 0) && !hold_busy;
    end
  end

  // Model: occupancy = accepted - issued; issue order = acceptance order;
  // completions = done pulses seen while a transaction is outstanding.
  always @(posedge clock) begin
    if (reset) begin
      acc_q.delete();
      acc = 0;
      issues = 0;
      model_done = 0;
      outst = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (writer_start && !prev_start) begin
        issued_q.push_back({writer_addr, writer_data});
        issues++;
        outst = 1'b1;
        if (acc_q.size() == 0) ord_err++;
        else if (acc_q.pop_front() !== {writer_addr, writer_data}) ord_err++;
      end
      if (int'(level) != acc - issues) lvl_err++;
      if (in_ready !== ((acc - issues) < DEPTH)) rdy_err++;
      if (done_count !== 32'(model_done)) cnt_err++;
      if (writer_done && outst) begin
        model_done++;
        outst = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_q.push_back({in_addr, in_data});
        acc++;
      end
      prev_start = writer_start;
    end
  end

  task automatic wait_quiet(input int max_cyc, output bit ok, output int pk);
    ok = 1'b0;
    pk = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (int'(level) > pk) pk = int'(level);
      if (!busy && !writer_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (16) @(negedge clock);
    tests_run++;
    if ({in_ready, writer_start, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/start/busy=%b expected 100", {in_ready, writer_start, busy});
    end
    tests_run++;
    if (writer_addr !== '0 || writer_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_args: addr=%h data=%h expected 0", writer_addr, writer_data);
    end
    tests_run++;
    if (level !== 4'd0 || done_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: level=%0d done_count=%0d expected 0/0", level, done_count);
    end
    reset = 1'b0;
    exp_done = 0;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({in_ready, writer_start, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release: ready/start/busy=%b expected 100", {in_ready, writer_start, busy});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    int pk;
    int base;
    base = issued_q.size();
    rdy_dly = 0;
    done_dly = 3;
    hold_busy = 1'b0;
    in_valid = 1'b1;
    in_addr = 64'h01;
    in_data = 256'd101;
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if (level !== 4'd1 || writer_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_queued: level=%0d start=%b expected 1/0", level, writer_start);
    end
    @(negedge clock);
    tests_run++;
    if (writer_start !== 1'b1 || writer_addr !== 64'h01 || writer_data !== 256'd101) begin
      tests_failed++;
      $display("FAIL single_issue: start=%b addr=%h data=%0d expected 1/01/101", writer_start, writer_addr, writer_data);
    end
    @(negedge clock);
    tests_run++;
    if (writer_start !== 1'b0 || writer_addr !== 64'h01) begin
      tests_failed++;
      $display("FAIL single_start_drop: start=%b addr=%h expected 0/01", writer_start, writer_addr);
    end
    wait_quiet(50, ok, pk);
    exp_done++;
    tests_run++;
    if (!ok || done_count !== 32'(exp_done) || issued_q.size() != base + 1) begin
      tests_failed++;
      $display("FAIL single_done: quiet=%b done_count=%0d issued=%0d expected 1/%0d/%0d", ok, done_count, issued_q.size() - base, exp_done, 1);
    end
    $display("[TB] test_single done_count=%0d", done_count);
  endtask

  task automatic test_burst();
    bit ok;
    int pk;
    int base;
    int bad;
    base = issued_q.size();
    rdy_dly = 0;
    done_dly = 10;
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_addr = 64'(i);
      in_data = 256'(100 + i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    wait_quiet(400, ok, pk);
    exp_done += 7;
    tests_run++;
    if (!ok || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_drain: quiet=%b busy=%b expected 1/0", ok, busy);
    end
    tests_run++;
    if (pk != 6) begin
      tests_failed++;
      $display("FAIL burst_peak: level peak=%0d expected 6", pk);
    end
    tests_run++;
    if (done_count !== 32'(exp_done)) begin
      tests_failed++;
      $display("FAIL burst_count: done_count=%0d expected %0d", done_count, exp_done);
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (base + i >= issued_q.size()) bad++;
      else if (issued_q[base + i] !== {64'(i + 1), 256'(101 + i)}) bad++;
    end
    tests_run++;
    if (bad != 0 || issued_q.size() != base + 7) begin
      tests_failed++;
      $display("FAIL burst_order: %0d wrong of %0d issued, expected 0 wrong of 7", bad, issued_q.size() - base);
    end
    $display("[TB] test_burst peak=%0d done_count=%0d", pk, done_count);
  endtask

  task automatic test_full();
    bit ok;
    int pk;
    int base;
    int bad;
    req_t exp[8];
    base = issued_q.size();
    rdy_dly = $urandom_range(0, 2);
    done_dly = $urandom_range(0, 3);
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_addr = 64'h10 + 64'(i);
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
      if (i < 8) exp[i] = {in_addr, in_data};
      if (i == 8) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_ready: in_ready=%b with 8 queued, expected 0", in_ready);
        end
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    tests_run++;
    if (level !== 4'd8 || in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_level: level=%0d ready=%b busy=%b expected 8/0/1", level, in_ready, busy);
    end
    hold_busy = 1'b0;
    wait_quiet(600, ok, pk);
    exp_done += 8;
    tests_run++;
    if (!ok || in_ready !== 1'b1 || done_count !== 32'(exp_done)) begin
      tests_failed++;
      $display("FAIL full_drain: quiet=%b ready=%b done_count=%0d expected 1/1/%0d", ok, in_ready, done_count, exp_done);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (base + i >= issued_q.size()) bad++;
      else if (issued_q[base + i] !== exp[i]) bad++;
    end
    tests_run++;
    if (bad != 0 || issued_q.size() != base + 8) begin
      tests_failed++;
      $display("FAIL full_order: %0d wrong of %0d issued, expected 0 wrong of 8", bad, issued_q.size() - base);
    end
    $display("[TB] test_full done_count=%0d", done_count);
  endtask

  task automatic test_corner();
    int base;
    base = issued_q.size();
    rdy_dly = 0;
    done_dly = 0;
    in_valid = 1'b1;
    in_addr = 64'h20;
    in_data = 256'd200;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    exp_done++;
    tests_run++;
    if (done_count !== 32'(exp_done) || writer_start !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_ready_done: done_count=%0d start=%b busy=%b expected %0d/0/0", done_count, writer_start, busy, exp_done);
    end
    spur_req += 3;
    repeat (6) @(negedge clock);
    tests_run++;
    if (done_count !== 32'(exp_done) || issued_q.size() != base + 1 || writer_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_spurious: done_count=%0d issued=%0d start=%b expected %0d/1/0", done_count, issued_q.size() - base, writer_start, exp_done);
    end
    $display("[TB] test_corner done_count=%0d", done_count);
  endtask

  task automatic test_random();
    bit ok;
    int pk;
    int base;
    int bad;
    req_t exp_q[$];
    base = issued_q.size();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) hold_busy = !hold_busy;
      rdy_dly = $urandom_range(0, 3);
      done_dly = $urandom_range(0, 4);
      in_valid = ($urandom_range(0, 2) != 0);
      in_addr = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
      if (in_valid && in_ready) exp_q.push_back({in_addr, in_data});
      @(negedge clock);
    end
    in_valid = 1'b0;
    hold_busy = 1'b0;
    wait_quiet(2000, ok, pk);
    exp_done += exp_q.size();
    tests_run++;
    if (!ok || done_count !== 32'(exp_done)) begin
      tests_failed++;
      $display("FAIL random_count: quiet=%b done_count=%0d expected %0d", ok, done_count, exp_done);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= issued_q.size()) bad++;
      else if (issued_q[base + i] !== exp_q[i]) bad++;
    end
    tests_run++;
    if (bad != 0 || issued_q.size() != base + exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_order: %0d wrong, issued %0d, expected 0 wrong, %0d issued", bad, issued_q.size() - base, exp_q.size());
    end
    tests_run++;
    if (lvl_err != 0 || rdy_err != 0 || cnt_err != 0 || ord_err != 0) begin
      tests_failed++;
      $display("FAIL random_invariants: level=%0d ready=%0d count=%0d order=%0d violations, expected 0", lvl_err, rdy_err, cnt_err, ord_err);
    end
    $display("[TB] test_random accepted=%0d done_count=%0d", exp_q.size(), done_count);
  endtask

  task automatic test_reset_midop();
    int base;
    rdy_dly = 0;
    done_dly = 20;
    hold_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr = 64'h30 + 64'(i);
      in_data = 256'(300 + i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (level !== 4'd3 || writer_start !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_pre: level=%0d start=%b busy=%b expected 3/0/1", level, writer_start, busy);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (level !== 4'd0 || done_count !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_wait_reset: level=%0d done_count=%0d busy=%b ready=%b expected 0/0/0/1", level, done_count, busy, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_done = 0;
    rdy_dly = 40;
    in_valid = 1'b1;
    in_addr = 64'h40;
    in_data = 256'd400;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    tests_run++;
    if (writer_start !== 1'b1 || writer_addr !== 64'h40) begin
      tests_failed++;
      $display("FAIL midop_start_pre: start=%b addr=%h expected 1/40", writer_start, writer_addr);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (writer_start !== 1'b0 || writer_addr !== '0 || writer_data !== '0) begin
      tests_failed++;
      $display("FAIL midop_start_reset: start=%b addr=%h data=%h expected 0/0/0", writer_start, writer_addr, writer_data);
    end
    @(negedge clock);
    reset = 1'b0;
    rdy_dly = 0;
    done_dly = 2;
    @(negedge clock);
    base = issued_q.size();
    repeat (30) @(negedge clock);
    tests_run++;
    if (issued_q.size() != base || writer_start !== 1'b0 || busy !== 1'b0 || done_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL midop_stale: issued=%0d start=%b busy=%b done_count=%0d expected 0/0/0/0", issued_q.size() - base, writer_start, busy, done_count);
    end
    $display("[TB] test_reset_midop done_count=%0d", done_count);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_corner();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
